// File: rtl/palette_arbiter.sv
// Round-robin arbiter sharing one combinational palette between NUM_REQ pixel requesters.
// Two-stage pipeline: stage A drives the palette index, stage B holds the looked-up response.
module palette_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter logic [3:0] TRANSP_IDX = 4'h0,
  localparam int        ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_index,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           pal_index,
  input  logic [11:0]          pal_rgb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [11:0]          rsp_rgb,
  output logic                 rsp_transp
);

  logic            vld_p0;
  logic [ID_W-1:0] id_p0;
  logic [3:0]      idx_p0;
  logic            vld_p1;
  logic [ID_W-1:0] id_p1;
  logic [11:0]     rgb_p1;
  logic            transp_p1;

  logic [ID_W-1:0] last_grant;
  logic            stall;

  logic            hi_found, lo_found, gnt_found;
  logic [ID_W-1:0] hi_id, lo_id, gnt_id;
  logic [3:0]      hi_idx, lo_idx, gnt_idx;

  assign stall = vld_p1 & ~rsp_ready;

  // Round-robin: lowest valid requester above last_grant wins, else wrap to the lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
        lo_idx   = req_index[4*i +: 4];
        if (ID_W'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
          hi_idx   = req_index[4*i +: 4];
        end
      end
    end
    gnt_found = lo_found;
    gnt_id    = hi_found ? hi_id  : lo_id;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = reset_n & ~stall & gnt_found & (gnt_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0     <= 1'b0;
      id_p0      <= '0;
      idx_p0     <= 4'h0;
      vld_p1     <= 1'b0;
      id_p1      <= '0;
      rgb_p1     <= 12'h000;
      transp_p1  <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (!stall) begin
      // Stage A: granted request, or a bubble that keeps the previous index on the palette
      vld_p0 <= gnt_found;
      if (gnt_found) begin
        id_p0      <= gnt_id;
        idx_p0     <= gnt_idx;
        last_grant <= gnt_id;
      end
      // Stage B: capture palette lookup for whatever stage A holds
      vld_p1    <= vld_p0;
      id_p1     <= id_p0;
      rgb_p1    <= pal_rgb;
      transp_p1 <= (idx_p0 == TRANSP_IDX);
    end
  end

  assign pal_index  = idx_p0;
  assign rsp_valid  = vld_p1;
  assign rsp_id     = id_p1;
  assign rsp_rgb    = rgb_p1;
  assign rsp_transp = transp_p1;

endmodule

// File: doc/palette_arbiter.md
PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of pixel requesters (sprite/background layers).
REQ-002 The block SHALL have parameter TRANSP_IDX, default 4'h0, giving the palette index reported as transparent.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester lookup request.
REQ-006 req_index  input  4*NUM_REQ  per-requester 4-bit palette index; requester i uses bits [4i+3:4i].
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 pal_index  output  4  index presented to the shared combinational 16-entry palette.
REQ-009 pal_rgb  input  12  {red, green, blue}, 4 bits each, returned combinationally by the palette for pal_index.
REQ-010 rsp_valid  output  1  response valid.
REQ-011 rsp_ready  input  1  response consumer accept.
REQ-012 rsp_id  output  log2(NUM_REQ)  requester number owning the response.
REQ-013 rsp_rgb  output  12  looked-up colour.
REQ-014 rsp_transp  output  1  high when the looked-up index equals TRANSP_IDX.

Function
REQ-015 A transfer SHALL occur on requester i in any cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 Pipeline: stage A holds {valid, id, index} and drives pal_index; stage B holds {rsp_valid, rsp_id, rsp_rgb, rsp_transp}.
REQ-017 Latency: a request accepted at edge N SHALL drive pal_index after edge N, and SHALL appear on rsp_* after edge N+1, with no stall.
REQ-018 Throughput SHALL be one accepted request per cycle while rsp_ready stays high.
REQ-019 Stall condition: stall = rsp_valid and not rsp_ready; during stall, stages A and B SHALL hold their contents and every req_ready bit SHALL be 0.
REQ-020 Stage A SHALL load on any non-stall cycle: when a grant exists it loads the granted request; otherwise it loads valid=0.
REQ-021 Stage B SHALL load from stage A on any non-stall cycle: rsp_rgb from pal_rgb, rsp_transp from (stage A index == TRANSP_IDX), and rsp_valid from stage A valid.
REQ-022 Arbitration SHALL be round-robin: the search starts at requester (last_grant+1) mod NUM_REQ and the first requester with req_valid high is granted.
REQ-023 req_ready SHALL be combinational from req_valid, last_grant and stall; req_ready[i] is high only if req_valid[i] is high.
REQ-024 last_grant SHALL update to the granted id only on a transfer; with no transfer it SHALL hold.
REQ-025 Fairness: a requester holding req_valid high SHALL be granted within NUM_REQ non-stall cycles.
REQ-026 pal_index SHALL equal the stage A index, even when stage A valid is 0; the index value SHALL hold during a stall.
REQ-027 A requester deasserting req_valid before it is granted SHALL lose nothing, and no response SHALL be generated for it.
REQ-028 Responses SHALL leave the block in acceptance order; the pipeline SHALL never drop or duplicate a response.

Reset
REQ-029 While reset_n is low, the block SHALL set: stage A valid=0, index=0; rsp_valid=0, rsp_id=0, rsp_rgb=12'h000, rsp_transp=0; last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
REQ-030 req_ready SHALL be all-zero while reset_n is low.
REQ-031 Asserting reset mid-transfer SHALL discard all in-flight requests; after release, no response SHALL be emitted for them.

Verification
The bench palette model returns pal_rgb = {idx, ~idx, 4'h0}.
REQ-032 Single request: req 2 valid, index 5, rsp_ready=1 -> req_ready=4'b0100 for one cycle; two edges later rsp_valid=1, rsp_id=2, rsp_rgb=12'h5A0, rsp_transp=0.
REQ-033 Contention: all four valid continuously, rsp_ready=1, first stimulus after reset -> grant order 0,1,2,3,0,...; one response per cycle with ids in the same order.
REQ-034 Backpressure: two requests in flight and rsp_ready=0 for 3 cycles -> rsp_* stable, req_ready=0, pal_index held; after release the two responses appear on consecutive cycles in order.
REQ-035 Transparency: index 0 from req 1 -> rsp_transp=1, rsp_rgb=12'h0F0.
REQ-036 Reset mid-flight: reset_n low for 1 cycle with stage A and stage B both valid -> rsp_valid=0 immediately (asynchronous); after release, no stale response; next grant goes to the lowest valid requester.
REQ-037 Withdrawal: req 3 valid for 1 cycle while req 0 is granted, then deasserted -> no response with rsp_id=3.
